// File: rtl/algo_3r1w_rd_sched_if.sv
// Bus bundle for the 3R1W read scheduler: requester side, write channel
// and the memory-facing read/write ports. The scheduler uses the slave view;
// requesters plus memory (or a bench) use the master view.
interface algo_3r1w_rd_sched_if #(
  parameter int NUMREQ   = 6,
  parameter int NUMRDPRT = 3,
  parameter int BITADDR  = 8,
  parameter int WIDTH    = 15
);
  logic [NUMREQ-1:0]            req_vld;
  logic [NUMREQ*BITADDR-1:0]    req_adr;
  logic [NUMREQ-1:0]            req_rdy;
  logic [NUMREQ-1:0]            rsp_vld;
  logic [NUMREQ*WIDTH-1:0]      rsp_data;
  logic                         wr_vld;
  logic [BITADDR-1:0]           wr_adr;
  logic [WIDTH-1:0]             wr_din;
  logic [WIDTH-1:0]             wr_bw;
  logic [NUMRDPRT-1:0]          read;
  logic [NUMRDPRT*BITADDR-1:0]  rd_adr;
  logic [NUMRDPRT*WIDTH-1:0]    rd_dout;
  logic [NUMRDPRT-1:0]          rd_vld;
  logic                         write;
  logic [BITADDR-1:0]           wr_adr_m;
  logic [WIDTH-1:0]             din;
  logic [WIDTH-1:0]             bw;
  logic                         err;

  modport slave (
    input  req_vld, req_adr, wr_vld, wr_adr, wr_din, wr_bw, rd_dout, rd_vld,
    output req_rdy, rsp_vld, rsp_data, read, rd_adr, write, wr_adr_m, din, bw, err
  );

  modport master (
    output req_vld, req_adr, wr_vld, wr_adr, wr_din, wr_bw, rd_dout, rd_vld,
    input  req_rdy, rsp_vld, rsp_data, read, rd_adr, write, wr_adr_m, din, bw, err
  );
endinterface

// File: rtl/algo_3r1w_rd_sched.sv
// Round-robin read scheduler sharing NUMRDPRT memory read ports among NUMREQ
// requesters. Each issued read carries its requester id down a fixed-latency
// tag pipe so the returned data can be steered back; returns that do not
// match the expected pattern latch a sticky error. Writes pass straight through.
module algo_3r1w_rd_sched #(
  parameter int NUMREQ   = 6,
  parameter int BITREQ   = 3,
  parameter int NUMRDPRT = 3,
  parameter int BITADDR  = 8,
  parameter int WIDTH    = 15,
  parameter int RD_DELAY = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  algo_3r1w_rd_sched_if.slave bus_if
);
  localparam int DEPTH = (RD_DELAY == 0) ? 1 : RD_DELAY;

  logic [BITREQ-1:0]           ptr_q, ptr_d;
  logic [NUMREQ-1:0]           gnt;
  logic [NUMRDPRT-1:0]         rd_en;
  logic [NUMRDPRT*BITADDR-1:0] rd_adr_w;
  logic [BITREQ-1:0]           gnt_id [NUMRDPRT];

  logic [NUMRDPRT-1:0]         tag_vld_q [DEPTH];
  logic [BITREQ-1:0]           tag_id_q  [DEPTH][NUMRDPRT];
  logic [NUMRDPRT-1:0]         exp_vld;
  logic [BITREQ-1:0]           exp_id    [NUMRDPRT];

  logic [3:0]                  blk_q;
  logic [NUMREQ-1:0]           rsp_vld_q, rsp_vld_d;
  logic [NUMREQ*WIDTH-1:0]     rsp_data_q, rsp_data_d;
  logic                        err_q;
  logic                        err_hit;

  // Scan from ptr, grant the first NUMRDPRT valid requesters to ports in scan order.
  always_comb begin
    int idx;
    int n;
    int last;
    idx      = 0;
    n        = 0;
    last     = int'(ptr_q);
    gnt      = '0;
    rd_en    = '0;
    rd_adr_w = '0;
    for (int p = 0; p < NUMRDPRT; p++) gnt_id[p] = '0;
    if (!rst_i) begin
      for (int k = 0; k < NUMREQ; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= NUMREQ) idx = idx - NUMREQ;
        if (bus_if.req_vld[idx] && (n < NUMRDPRT)) begin
          gnt[idx]                          = 1'b1;
          rd_en[n]                          = 1'b1;
          rd_adr_w[n*BITADDR +: BITADDR]    = bus_if.req_adr[idx*BITADDR +: BITADDR];
          gnt_id[n]                         = BITREQ'(idx);
          last                              = idx;
          n                                 = n + 1;
        end
      end
    end
    ptr_d = ptr_q;
    if (n != 0) ptr_d = (last + 1 >= NUMREQ) ? '0 : BITREQ'(last + 1);
  end

  // Tag pipe: one {vld, id} stage per cycle of memory latency, per port.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < DEPTH; s++) begin
        tag_vld_q[s] <= '0;
        for (int p = 0; p < NUMRDPRT; p++) tag_id_q[s][p] <= '0;
      end
    end else begin
      tag_vld_q[0] <= rd_en;
      for (int p = 0; p < NUMRDPRT; p++) tag_id_q[0][p] <= gnt_id[p];
      for (int s = 1; s < DEPTH; s++) begin
        tag_vld_q[s] <= tag_vld_q[s-1];
        for (int p = 0; p < NUMRDPRT; p++) tag_id_q[s][p] <= tag_id_q[s-1][p];
      end
    end
  end

  // With zero memory latency the expectation is the current grant itself.
  if (RD_DELAY == 0) begin : g_nodly
    always_comb begin
      exp_vld = rd_en;
      for (int p = 0; p < NUMRDPRT; p++) exp_id[p] = gnt_id[p];
    end
  end else begin : g_dly
    always_comb begin
      exp_vld = tag_vld_q[DEPTH-1];
      for (int p = 0; p < NUMRDPRT; p++) exp_id[p] = tag_id_q[DEPTH-1][p];
    end
  end

  // Steer returned data by the expected tag; rd_vld never influences routing.
  always_comb begin
    rsp_vld_d  = '0;
    rsp_data_d = rsp_data_q;
    for (int p = 0; p < NUMRDPRT; p++) begin
      if (exp_vld[p] && (int'(exp_id[p]) < NUMREQ)) begin
        rsp_vld_d[exp_id[p]]                       = 1'b1;
        rsp_data_d[int'(exp_id[p])*WIDTH +: WIDTH] = bus_if.rd_dout[p*WIDTH +: WIDTH];
      end
    end
  end

  assign err_hit = (blk_q == 4'd0) && (bus_if.rd_vld != exp_vld);

  // Blackout down-counter hides returns of reads issued before reset.
  always_ff @(posedge clk_i) begin
    if (rst_i)               blk_q <= 4'(RD_DELAY);
    else if (blk_q != 4'd0)  blk_q <= blk_q - 4'd1;
  end

  // Pointer, registered responses and sticky error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q      <= '0;
      rsp_vld_q  <= '0;
      rsp_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_data_q <= rsp_data_d;
      err_q      <= err_q | err_hit;
    end
  end

  assign bus_if.req_rdy  = gnt;
  assign bus_if.read     = rd_en;
  assign bus_if.rd_adr   = rd_adr_w;
  assign bus_if.rsp_vld  = rsp_vld_q;
  assign bus_if.rsp_data = rsp_data_q;
  assign bus_if.err      = err_q;
  assign bus_if.write    = bus_if.wr_vld & ~rst_i;
  assign bus_if.wr_adr_m = bus_if.wr_adr;
  assign bus_if.din      = bus_if.wr_din;
  assign bus_if.bw       = bus_if.wr_bw;
endmodule

// File: tb/tb_algo_3r1w_rd_sched.sv
// Directed bench for the 3R1W read scheduler: one instance with a 1-cycle
// memory, one with a 2-cycle memory for the reset/blackout scenario.
module tb_algo_3r1w_rd_sched;
  localparam int NQ = 6;
  localparam int NP = 3;
  localparam int AW = 8;
  localparam int DW = 15;

  logic clk = 1'b0;
  logic rst, rst2;
  int   n_chk = 0;
  int   n_bad = 0;
  logic auto_mem = 1'b0;
  logic [NQ-1:0] hist0, hist1;

  always #5 clk = ~clk;

  algo_3r1w_rd_sched_if #(.NUMREQ(NQ), .NUMRDPRT(NP), .BITADDR(AW), .WIDTH(DW)) bus  ();
  algo_3r1w_rd_sched_if #(.NUMREQ(NQ), .NUMRDPRT(NP), .BITADDR(AW), .WIDTH(DW)) bus2 ();

  algo_3r1w_rd_sched #(.NUMREQ(NQ), .BITREQ(3), .NUMRDPRT(NP), .BITADDR(AW),
                       .WIDTH(DW), .RD_DELAY(1)) dut  (.clk_i(clk), .rst_i(rst),  .bus_if(bus));
  algo_3r1w_rd_sched #(.NUMREQ(NQ), .BITREQ(3), .NUMRDPRT(NP), .BITADDR(AW),
                       .WIDTH(DW), .RD_DELAY(2)) dut2 (.clk_i(clk), .rst_i(rst2), .bus_if(bus2));

  function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
    return {a[6:0] ^ 7'h2A, a};
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; the auto memory returns what was read last cycle.
  task automatic tick();
    logic [NP-1:0]    cr;
    logic [NP*AW-1:0] ca;
    cr = bus.read;
    ca = bus.rd_adr;
    @(posedge clk);
    #1;
    if (auto_mem) begin
      bus.rd_vld = cr;
      for (int p = 0; p < NP; p++)
        bus.rd_dout[p*DW +: DW] = cr[p] ? mdata(ca[p*AW +: AW]) : '0;
    end
  endtask

  // One request cycle: check grants now, responses from two cycles ago.
  task automatic vec(input string tag, input logic [NQ-1:0] vld, input logic [NQ-1:0] e_rdy,
                     input logic [NP-1:0] e_rd, input logic [NP*AW-1:0] e_adr);
    bus.req_vld = vld;
    #2;
    chk({tag, ".rdy"}, bus.req_rdy, e_rdy);
    chk({tag, ".read"}, bus.read, e_rd);
    chk({tag, ".rd_adr"}, bus.rd_adr, e_adr);
    chk({tag, ".rsp_vld"}, bus.rsp_vld, hist1);
    for (int i = 0; i < NQ; i++)
      if (hist1[i]) chk({tag, ".rsp_data"}, bus.rsp_data[i*DW +: DW], mdata(8'(8'hA0 + i)));
    tick();
    hist1 = hist0;
    hist0 = e_rdy;
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    bus.req_vld = '0; bus.req_adr = '0; bus.wr_vld = 1'b0; bus.wr_adr = '0;
    bus.wr_din = '0; bus.wr_bw = '0; bus.rd_dout = '0; bus.rd_vld = '0;
    bus2.req_vld = '0; bus2.req_adr = '0; bus2.wr_vld = 1'b0; bus2.wr_adr = '0;
    bus2.wr_din = '0; bus2.wr_bw = '0; bus2.rd_dout = '0; bus2.rd_vld = '0;
    hist0 = '0; hist1 = '0;
    tick(); tick();

    // Reset state and gating of combinational outputs
    bus.req_vld = '1; bus.wr_vld = 1'b1;
    #2;
    chk("rst.rdy", bus.req_rdy, 6'b0);
    chk("rst.read", bus.read, 3'b0);
    chk("rst.write", bus.write, 1'b0);
    chk("rst.rsp_vld", bus.rsp_vld, 6'b0);
    chk("rst.rsp_data", bus.rsp_data, 90'b0);
    chk("rst.err", bus.err, 1'b0);
    bus.req_vld = '0; bus.wr_vld = 1'b0; rst = 1'b0;
    tick();

    // Single requester 4, data returned by hand one cycle later
    bus.req_adr[4*AW +: AW] = 8'h3C;
    bus.req_vld = 6'b010000;
    #2;
    chk("t1.rdy", bus.req_rdy, 6'b010000);
    chk("t1.read", bus.read, 3'b001);
    chk("t1.rd_adr", bus.rd_adr, 24'h00003C);
    tick();
    bus.req_vld = '0; bus.rd_vld = 3'b001; bus.rd_dout = '0; bus.rd_dout[14:0] = 15'h1234;
    #2;
    chk("t1.rsp_early", bus.rsp_vld, 6'b0);
    tick();
    bus.rd_vld = '0;
    chk("t1.rsp_vld", bus.rsp_vld, 6'b010000);
    chk("t1.rsp_data", bus.rsp_data[4*DW +: DW], 15'h1234);
    chk("t1.err", bus.err, 1'b0);
    tick();

    // Round robin with an auto-responding memory; ptr is 5 after test 1
    for (int i = 0; i < NQ; i++) bus.req_adr[i*AW +: AW] = 8'(8'hA0 + i);
    auto_mem = 1'b1;
    vec("rr1", 6'b111111, 6'b100011, 3'b111, 24'hA1A0A5);
    vec("rr2", 6'b100000, 6'b100000, 3'b001, 24'h0000A5);
    vec("rr3", 6'b111111, 6'b000111, 3'b111, 24'hA2A1A0);
    bus.wr_vld = 1'b1; bus.wr_adr = 8'h10; bus.wr_din = 15'h7FFF; bus.wr_bw = 15'h00FF;
    bus.req_vld = 6'b111111;
    #2;
    chk("wr.write", bus.write, 1'b1);
    chk("wr.adr", bus.wr_adr_m, 8'h10);
    chk("wr.din", bus.din, 15'h7FFF);
    chk("wr.bw", bus.bw, 15'h00FF);
    vec("rr4", 6'b111111, 6'b111000, 3'b111, 24'hA5A4A3);
    bus.wr_vld = 1'b0;
    vec("rr5", 6'b111111, 6'b000111, 3'b111, 24'hA2A1A0);
    vec("rr6", 6'b000001, 6'b000001, 3'b001, 24'h0000A0);
    vec("wrap", 6'b100001, 6'b100001, 3'b011, 24'h00A0A5);
    vec("ptr1", 6'b000011, 6'b000011, 3'b011, 24'h00A0A1);
    vec("idle1", 6'b000000, 6'b000000, 3'b000, 24'h0);
    vec("idle2", 6'b000000, 6'b000000, 3'b000, 24'h0);
    vec("idle3", 6'b000000, 6'b000000, 3'b000, 24'h0);
    vec("ptrhold", 6'b000011, 6'b000011, 3'b011, 24'h00A0A1);
    vec("drain1", 6'b000000, 6'b000000, 3'b000, 24'h0);
    vec("drain2", 6'b000000, 6'b000000, 3'b000, 24'h0);
    chk("rr.err", bus.err, 1'b0);

    // Unexpected return on port 2 sets the sticky error
    auto_mem = 1'b0;
    bus.rd_vld = 3'b100;
    tick();
    bus.rd_vld = '0;
    chk("err.set", bus.err, 1'b1);
    chk("err.no_rsp", bus.rsp_vld, 6'b0);
    tick(); tick(); tick();
    chk("err.sticky", bus.err, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("err.clr", bus.err, 1'b0);

    // Two-cycle memory: reset discards an in-flight tag and masks its return
    rst2 = 1'b0;
    tick(); tick(); tick();
    bus2.req_adr[2*AW +: AW] = 8'h55;
    bus2.req_vld = 6'b000100;
    #2;
    chk("r2.rdy", bus2.req_rdy, 6'b000100);
    chk("r2.rd_adr", bus2.rd_adr, 24'h000055);
    tick();
    rst2 = 1'b1;
    #2;
    chk("r2.rst_rdy", bus2.req_rdy, 6'b0);
    chk("r2.rst_read", bus2.read, 3'b0);
    tick();
    rst2 = 1'b0; bus2.req_vld = '0;
    bus2.rd_vld = 3'b001; bus2.rd_dout = '0; bus2.rd_dout[14:0] = 15'h0777;
    tick();
    chk("r2.rsp_a", bus2.rsp_vld, 6'b0);
    chk("r2.err_a", bus2.err, 1'b0);
    tick();
    bus2.rd_vld = '0;
    chk("r2.rsp_b", bus2.rsp_vld, 6'b0);
    chk("r2.err_b", bus2.err, 1'b0);
    tick();
    chk("r2.rsp_c", bus2.rsp_vld, 6'b0);
    chk("r2.err_c", bus2.err, 1'b0);

    // Two-cycle memory: response lands three cycles after the request
    bus2.req_adr[1*AW +: AW] = 8'h66;
    bus2.req_vld = 6'b000010;
    tick();
    bus2.req_vld = '0;
    tick();
    bus2.rd_vld = 3'b001; bus2.rd_dout[14:0] = 15'h0ABC;
    #2;
    chk("l2.rsp_early", bus2.rsp_vld, 6'b0);
    tick();
    bus2.rd_vld = '0;
    chk("l2.rsp_vld", bus2.rsp_vld, 6'b000010);
    chk("l2.rsp_data", bus2.rsp_data[1*DW +: DW], 15'h0ABC);
    chk("l2.err", bus2.err, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
